// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / link-use hazard detection, hold and flush handling.
// Optional stall counters are compiled in when ID_EX_STALL_CNT_EN is defined.
module id_ex_stage #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_ID,
  input  logic [3:0]          rs1,
  input  logic [3:0]          rs2,
  input  logic                uses_rs1,
  input  logic                uses_rs2,
  input  logic [XLEN-1:0]     rs1_data_ID,
  input  logic [XLEN-1:0]     rs2_data_ID,
  input  logic [3:0]          rd_ID,
  input  logic                regfile_we_ID,
  input  logic [1:0]          rd_data_sel_ID,
  input  logic [ALU_OP_W-1:0] alu_op_ID,
  input  logic [XLEN-1:0]     imm_ID,
  input  logic [XLEN-1:0]     pc4_ID,
  input  logic                regfile_we_MEMPREP,
  input  logic                regfile_we_MEMEX,
  input  logic                regfile_we_WB,
  input  logic [3:0]          rd_MEMPREP,
  input  logic [3:0]          rd_MEMEX,
  input  logic [3:0]          rd_WB,
  input  logic [1:0]          rd_data_sel_MEMPREP,
  input  logic [1:0]          rd_data_sel_MEMEX,
  input  logic [1:0]          rd_data_sel_WB,
  input  logic                hold_in,
  input  logic                flush_in,
  output logic                stall_ID,
  output logic                valid_EX,
  output logic                regfile_we_EX,
  output logic [3:0]          rd_EX,
  output logic [1:0]          rd_data_sel_EX,
  output logic [ALU_OP_W-1:0] alu_op_EX,
  output logic [XLEN-1:0]     rs1_data_EX,
  output logic [XLEN-1:0]     rs2_data_EX,
  output logic [XLEN-1:0]     imm_EX,
  output logic [XLEN-1:0]     pc4_EX
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]         hazard_stall_cnt,
  output logic [31:0]         hold_stall_cnt
`endif
);

  localparam logic [1:0] RD_DATA_SEL_MEM = 2'd1;
  localparam logic [1:0] RD_DATA_SEL_PC4 = 2'd2;

  localparam logic [1:0] ACT_ADVANCE = 2'd0;
  localparam logic [1:0] ACT_HAZARD  = 2'd1;
  localparam logic [1:0] ACT_FLUSH   = 2'd2;
  localparam logic [1:0] ACT_HOLD    = 2'd3;

  logic       pending_flush;
  logic       hit_ex;
  logic       hit_memprep;
  logic       hit_memex;
  logic       hit_wb;
  logic       hazard;
  logic [1:0] act;

  function automatic logic src_match(input logic       uses,
                                     input logic [3:0] rs,
                                     input logic       we,
                                     input logic [3:0] rd);
    return uses && (rs != 4'd0) && we && (rd == rs);
  endfunction

  function automatic logic prod_match(input logic       we,
                                      input logic [3:0] rd,
                                      input logic       u1,
                                      input logic [3:0] r1,
                                      input logic       u2,
                                      input logic [3:0] r2);
    return src_match(u1, r1, we, rd) || src_match(u2, r2, we, rd);
  endfunction

  // EX cannot forward a load or a link value yet; later stages only lack load data.
  always_comb begin
    hit_ex      = valid_EX
                  && ((rd_data_sel_EX == RD_DATA_SEL_MEM) || (rd_data_sel_EX == RD_DATA_SEL_PC4))
                  && prod_match(regfile_we_EX, rd_EX, uses_rs1, rs1, uses_rs2, rs2);
    hit_memprep = (rd_data_sel_MEMPREP == RD_DATA_SEL_MEM)
                  && prod_match(regfile_we_MEMPREP, rd_MEMPREP, uses_rs1, rs1, uses_rs2, rs2);
    hit_memex   = (rd_data_sel_MEMEX == RD_DATA_SEL_MEM)
                  && prod_match(regfile_we_MEMEX, rd_MEMEX, uses_rs1, rs1, uses_rs2, rs2);
    hit_wb      = (rd_data_sel_WB == RD_DATA_SEL_MEM)
                  && prod_match(regfile_we_WB, rd_WB, uses_rs1, rs1, uses_rs2, rs2);
    hazard      = valid_ID && !pending_flush
                  && (hit_ex || hit_memprep || hit_memex || hit_wb);
  end

  always_comb begin
    act = ACT_ADVANCE;
    if (hold_in)
      act = ACT_HOLD;
    else if (flush_in || pending_flush)
      act = ACT_FLUSH;
    else if (hazard)
      act = ACT_HAZARD;
  end

  // While in reset the EX register is empty, so only a downstream hold may stall ID.
  assign stall_ID = (act == ACT_HOLD) || (rst_n && (act == ACT_HAZARD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_flush  <= 1'b0;
      valid_EX       <= 1'b0;
      regfile_we_EX  <= 1'b0;
      rd_EX          <= '0;
      rd_data_sel_EX <= '0;
      alu_op_EX      <= '0;
      rs1_data_EX    <= '0;
      rs2_data_EX    <= '0;
      imm_EX         <= '0;
      pc4_EX         <= '0;
    end else begin
      case (act)
        ACT_HOLD: begin
          pending_flush <= pending_flush | flush_in;
        end
        ACT_FLUSH, ACT_HAZARD: begin
          pending_flush  <= 1'b0;
          valid_EX       <= 1'b0;
          regfile_we_EX  <= 1'b0;
          rd_EX          <= '0;
          rd_data_sel_EX <= '0;
          alu_op_EX      <= '0;
          rs1_data_EX    <= '0;
          rs2_data_EX    <= '0;
          imm_EX         <= '0;
          pc4_EX         <= '0;
        end
        default: begin
          valid_EX       <= valid_ID;
          regfile_we_EX  <= regfile_we_ID & valid_ID;
          rd_EX          <= rd_ID;
          rd_data_sel_EX <= rd_data_sel_ID;
          alu_op_EX      <= alu_op_ID;
          rs1_data_EX    <= rs1_data_ID;
          rs2_data_EX    <= rs2_data_ID;
          imm_EX         <= imm_ID;
          pc4_EX         <= pc4_ID;
        end
      endcase
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazard_stall_cnt <= '0;
      hold_stall_cnt   <= '0;
    end else begin
      if ((act == ACT_HAZARD) && (hazard_stall_cnt != '1))
        hazard_stall_cnt <= hazard_stall_cnt + 32'd1;
      if ((act == ACT_HOLD) && (hold_stall_cnt != '1))
        hold_stall_cnt <= hold_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed + randomized bench for id_ex_stage against a stage-list reference model.
module tb_id_ex_stage;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 4;
  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_PC4 = 2'd2;

  typedef struct {
    logic        valid;
    logic        we;
    logic [3:0]  rd;
    logic [1:0]  sel;
    logic [3:0]  alu;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [31:0] pc4;
  } ex_t;

  typedef struct {
    logic       we;
    logic [3:0] rd;
    logic [1:0] sel;
  } prod_t;

  logic clk = 1'b0;
  logic rst_n;
  logic valid_ID, uses_rs1, uses_rs2, regfile_we_ID, hold_in, flush_in;
  logic [3:0] rs1, rs2, rd_ID;
  logic [1:0] rd_data_sel_ID;
  logic [ALU_OP_W-1:0] alu_op_ID;
  logic [XLEN-1:0] rs1_data_ID, rs2_data_ID, imm_ID, pc4_ID;
  logic stall_ID, valid_EX, regfile_we_EX;
  logic [3:0] rd_EX;
  logic [1:0] rd_data_sel_EX;
  logic [ALU_OP_W-1:0] alu_op_EX;
  logic [XLEN-1:0] rs1_data_EX, rs2_data_EX, imm_EX, pc4_EX;
`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] hazard_stall_cnt, hold_stall_cnt;
`endif

  prod_t down[3];
  ex_t   m_ex;
  logic  m_pf;
  logic [31:0] m_hz_cnt, m_hold_cnt;
  logic  obs_stall, last_exp_stall;
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_ID(valid_ID),
    .rs1(rs1), .rs2(rs2), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
    .rs1_data_ID(rs1_data_ID), .rs2_data_ID(rs2_data_ID),
    .rd_ID(rd_ID), .regfile_we_ID(regfile_we_ID), .rd_data_sel_ID(rd_data_sel_ID),
    .alu_op_ID(alu_op_ID), .imm_ID(imm_ID), .pc4_ID(pc4_ID),
    .regfile_we_MEMPREP(down[0].we), .regfile_we_MEMEX(down[1].we), .regfile_we_WB(down[2].we),
    .rd_MEMPREP(down[0].rd), .rd_MEMEX(down[1].rd), .rd_WB(down[2].rd),
    .rd_data_sel_MEMPREP(down[0].sel), .rd_data_sel_MEMEX(down[1].sel),
    .rd_data_sel_WB(down[2].sel),
    .hold_in(hold_in), .flush_in(flush_in), .stall_ID(stall_ID),
    .valid_EX(valid_EX), .regfile_we_EX(regfile_we_EX), .rd_EX(rd_EX),
    .rd_data_sel_EX(rd_data_sel_EX), .alu_op_EX(alu_op_EX),
    .rs1_data_EX(rs1_data_EX), .rs2_data_EX(rs2_data_EX), .imm_EX(imm_EX), .pc4_EX(pc4_EX)
`ifdef ID_EX_STALL_CNT_EN
    , .hazard_stall_cnt(hazard_stall_cnt), .hold_stall_cnt(hold_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Producers listed oldest-last; EX can only forward ALU/IMM results, later stages all but loads.
  function automatic logic ref_hazard();
    prod_t p[4];
    logic [3:0] src[2];
    logic       use_src[2];
    p[0] = '{we: m_ex.we && m_ex.valid, rd: m_ex.rd, sel: m_ex.sel};
    for (int i = 0; i < 3; i++) p[i+1] = down[i];
    src[0] = rs1; use_src[0] = uses_rs1;
    src[1] = rs2; use_src[1] = uses_rs2;
    if (!valid_ID || m_pf) return 1'b0;
    for (int i = 0; i < 4; i++)
      for (int s = 0; s < 2; s++)
        if (use_src[s] && src[s] != 0 && p[i].we && p[i].rd == src[s]
            && (p[i].sel == SEL_MEM || (i == 0 && p[i].sel == SEL_PC4)))
          return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_ex = '{valid: 1'b0, we: 1'b0, rd: '0, sel: '0, alu: '0, d1: '0, d2: '0, imm: '0, pc4: '0};
    m_pf = 1'b0;
    m_hz_cnt = '0;
    m_hold_cnt = '0;
    for (int i = 0; i < 3; i++) down[i] = '{we: 1'b0, rd: '0, sel: '0};
  endtask

  task automatic check_ex();
    chk("valid_EX", valid_EX, m_ex.valid);
    chk("regfile_we_EX", regfile_we_EX, m_ex.we);
    chk("rd_EX", rd_EX, m_ex.rd);
    chk("rd_data_sel_EX", rd_data_sel_EX, m_ex.sel);
    chk("alu_op_EX", alu_op_EX, m_ex.alu);
    chk("rs1_data_EX", rs1_data_EX, m_ex.d1);
    chk("rs2_data_EX", rs2_data_EX, m_ex.d2);
    chk("imm_EX", imm_EX, m_ex.imm);
    chk("pc4_EX", pc4_EX, m_ex.pc4);
`ifdef ID_EX_STALL_CNT_EN
    chk("hazard_stall_cnt", hazard_stall_cnt, m_hz_cnt);
    chk("hold_stall_cnt", hold_stall_cnt, m_hold_cnt);
`endif
  endtask

  // Called at posedge+1 with ID inputs driven; returns at the next posedge+1.
  task automatic step();
    logic hz;
    logic exp_stall;
    ex_t  old;
    @(negedge clk);
    hz = ref_hazard();
    exp_stall = hold_in || (!flush_in && !m_pf && hz);
    obs_stall = stall_ID;
    last_exp_stall = exp_stall;
    chk("stall_ID", stall_ID, exp_stall);
    old = m_ex;
    if (hold_in) begin
      m_pf = m_pf | flush_in;
      if (m_hold_cnt != 32'hFFFF_FFFF) m_hold_cnt = m_hold_cnt + 1;
    end else if (flush_in || m_pf) begin
      m_ex = '{valid: 1'b0, we: 1'b0, rd: '0, sel: '0, alu: '0, d1: '0, d2: '0, imm: '0, pc4: '0};
      m_pf = 1'b0;
    end else if (hz) begin
      m_ex = '{valid: 1'b0, we: 1'b0, rd: '0, sel: '0, alu: '0, d1: '0, d2: '0, imm: '0, pc4: '0};
      if (m_hz_cnt != 32'hFFFF_FFFF) m_hz_cnt = m_hz_cnt + 1;
    end else begin
      m_ex = '{valid: valid_ID, we: regfile_we_ID && valid_ID, rd: rd_ID, sel: rd_data_sel_ID,
               alu: alu_op_ID, d1: rs1_data_ID, d2: rs2_data_ID, imm: imm_ID, pc4: pc4_ID};
    end
    @(posedge clk);
    #1;
    if (!hold_in) begin
      down[2] = down[1];
      down[1] = down[0];
      down[0] = '{we: old.we, rd: old.rd, sel: old.sel};
    end
    check_ex();
  endtask

  task automatic set_id(input logic v, input logic [3:0] r1, input logic u1,
                        input logic [3:0] r2, input logic u2,
                        input logic [3:0] rd, input logic we, input logic [1:0] sel);
    valid_ID = v; rs1 = r1; uses_rs1 = u1; rs2 = r2; uses_rs2 = u2;
    rd_ID = rd; regfile_we_ID = we; rd_data_sel_ID = sel;
    alu_op_ID = 4'($urandom);
    rs1_data_ID = $urandom; rs2_data_ID = $urandom;
    imm_ID = $urandom; pc4_ID = $urandom;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    hold_in = 1'b0;
    flush_in = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, SEL_ALU);
    model_reset();
    #2;
    check_ex();
    chk("reset_stall", stall_ID, hold_in);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Load-use: producer in EX, consumer waits until it has left WB
    set_id(1, 0, 0, 0, 0, 5, 1, SEL_MEM); step();
    set_id(1, 5, 1, 0, 0, 7, 1, SEL_ALU); rs1_data_ID = 32'hDEAD_BEEF;
    n = 0;
    for (int k = 0; k < 8; k++) begin step(); if (obs_stall) n++; else break; end
    chk("loaduse_stall_cycles", n, 4);
    chk("loaduse_valid", valid_EX, 1);
    chk("loaduse_rs1_data", rs1_data_EX, 32'hDEAD_BEEF);

    // Link-use: one stall only
    set_id(1, 0, 0, 0, 0, 1, 1, SEL_PC4); step();
    set_id(1, 0, 0, 1, 1, 9, 1, SEL_ALU);
    n = 0;
    for (int k = 0; k < 8; k++) begin step(); if (obs_stall) n++; else break; end
    chk("jal_stall_cycles", n, 1);
    chk("jal_valid", valid_EX, 1);

    // x0 and unused source never stall
    set_id(1, 0, 0, 0, 0, 0, 1, SEL_MEM); step();
    set_id(1, 0, 1, 0, 0, 2, 1, SEL_ALU); step();
    chk("x0_stall", obs_stall, 0);
    chk("x0_valid", valid_EX, 1);
    set_id(1, 0, 0, 0, 0, 3, 1, SEL_MEM); step();
    set_id(1, 0, 0, 3, 0, 4, 1, SEL_ALU); step();
    chk("unused_stall", obs_stall, 0);
    chk("unused_rd", rd_EX, 4);

    // Flush during a 3-cycle hold
    set_id(1, 0, 0, 0, 0, 6, 1, SEL_ALU); step();
    set_id(1, 0, 0, 0, 0, 11, 1, SEL_ALU);
    hold_in = 1'b1; flush_in = 1'b1; step();
    flush_in = 1'b0; step(); step();
    chk("hold_rd_kept", rd_EX, 6);
    chk("hold_valid_kept", valid_EX, 1);
    hold_in = 1'b0; step();
    chk("pending_flush_bubble", valid_EX, 0);
    chk("pending_flush_stall", obs_stall, 0);
    step();
    chk("pending_flush_cleared", valid_EX, 1);

    // Flush while a hazard stall is active
    set_id(1, 0, 0, 0, 0, 8, 1, SEL_MEM); step();
    set_id(1, 0, 0, 8, 1, 10, 1, SEL_ALU); step();
    chk("hz_stall_before_flush", obs_stall, 1);
    flush_in = 1'b1; step();
    chk("flush_over_hazard_stall", obs_stall, 0);
    chk("flush_over_hazard_bubble", valid_EX, 0);
    flush_in = 1'b0;
    set_id(1, 0, 0, 0, 0, 11, 0, SEL_ALU); step();
    chk("post_flush_stall", obs_stall, 0);
    chk("post_flush_valid", valid_EX, 1);

    // Asynchronous reset in the middle of a hazard stall
    set_id(1, 0, 0, 0, 0, 12, 1, SEL_MEM); step();
    set_id(1, 12, 1, 0, 0, 13, 1, SEL_ALU);
    #1;
    chk("pre_reset_stall", stall_ID, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_ex();
    chk("reset_mid_hazard_stall", stall_ID, hold_in);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic; ID re-presents its instruction whenever it was told to stall
    last_exp_stall = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!last_exp_stall)
        set_id(logic'($urandom_range(0, 3) != 0),
               4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom),
               4'($urandom_range(0, 3)), 1'($urandom), 2'($urandom));
      hold_in = ($urandom_range(0, 5) == 0);
      flush_in = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
